// File: rtl/fetch_stage_pkg.sv
// Shared widths, boot address and state encoding for the instruction fetch stage.
package fetch_stage_pkg;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned INST_W  = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives word addresses to a registered-output ROM and
// presents the returning instruction to decode with stall and redirect support.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [WADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_inst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic [31:0]        fetch_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] fetch_pc;
  logic            accept;
  logic            unused_redirect_lsbs;

  // Byte offset of the redirect target is meaningless for word fetch.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // fetch_pc tracks the address the ROM registered last cycle, so if_pc
  // always matches imem_inst without any extra pipeline register.
  always_comb begin
    imem_addr = RESET_PC[PC_W-1:2];
    if (!rst && state == RUN) begin
      if (redirect_valid)
        imem_addr = redirect_pc[PC_W-1:2];
      else if (stall)
        imem_addr = fetch_pc[PC_W-1:2];
      else
        imem_addr = fetch_pc[PC_W-1:2] + {{(WADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign accept   = (state == RUN) && !stall && !redirect_valid;
  assign if_valid = (state == RUN);
  assign if_pc    = fetch_pc;
  assign if_inst  = imem_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state    <= RUN;
      fetch_pc <= {imem_addr, 2'b00};
      if (accept)
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: imem_addr  output  30  word address to the instruction ROM; the ROM registers it, and the data returns on imem_inst one cycle later.
REQ-005 Port: imem_inst  input  32  instruction word from the ROM for the address presented in the previous cycle.
REQ-006 Port: stall  input  1  decode cannot accept the current instruction; hold it.
REQ-007 Port: redirect_valid  input  1  branch/jump/exception redirect request.
REQ-008 Port: redirect_pc  input  32  byte address of the redirect target; bits [1:0] are ignored.
REQ-009 Port: if_valid  output  1  if_inst/if_pc hold a valid fetched instruction.
REQ-010 Port: if_pc  output  32  byte PC of if_inst.
REQ-011 Port: if_inst  output  32  fetched instruction, driven directly from imem_inst.
REQ-012 Port: fetch_count  output  32  number of instructions accepted by decode.
REQ-013 Parameter: RESET_PC, default 32'h00000000, boot byte address, word aligned.

Function
REQ-014 The block SHALL keep a registered fetch_pc whose instruction is the one currently on imem_inst; if_pc SHALL equal fetch_pc.
REQ-015 The block SHALL implement the states BOOT and RUN in a state register.
REQ-016 In BOOT, imem_addr SHALL be RESET_PC[31:2] and if_valid SHALL be 0; the next state is RUN, regardless of stall and redirect_valid.
REQ-017 In RUN, if_valid SHALL be 1.
REQ-018 In RUN, imem_addr SHALL be chosen by priority:
  - redirect_valid: redirect_pc[31:2];
  - else stall: fetch_pc[31:2] (re-present the address, so the ROM output holds);
  - else: fetch_pc[31:2]+1, wrapping modulo 2^30.
REQ-019 On every non-reset edge, fetch_pc SHALL load {imem_addr, 2'b00}.
REQ-020 Redirect latency SHALL be 1 cycle: in the cycle after redirect_valid, if_valid=1, if_pc=redirect target (bits [1:0] forced to 00) and if_inst=ROM[target].
REQ-021 The instruction shown in the redirect cycle is treated as squashed, and the block SHALL NOT count it.
REQ-022 Redirect and stall asserted together: redirect SHALL win.
REQ-023 fetch_count SHALL increment by 1 on each edge where if_valid=1, stall=0 and redirect_valid=0.
REQ-024 fetch_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-025 While stalled, if_pc and if_inst SHALL be stable for any number of cycles.
REQ-026 Sequential fetch from word 30'h3FFFFFFF SHALL wrap to word 0 (if_pc 32'h00000000).

Reset
REQ-027 While rst=1, imem_addr SHALL be RESET_PC[31:2].
REQ-028 While rst=1, the registers SHALL load: state=BOOT, fetch_pc=RESET_PC, fetch_count=0, so if_valid is 0 in the following cycle.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL override both; after rst deasserts, the first valid instruction SHALL be ROM[RESET_PC] two cycles later.

Structure
REQ-030 A shared package SHALL hold the state enum (BOOT, RUN), RESET_PC default, and the widths PC_W=32, WADDR_W=30, INST_W=32.
REQ-031 The block SHALL be a single module with no sub-modules; the ROM is external.

Verification
REQ-032 Reset release, no stall -> if_valid 0 for one cycle, then consecutive cycles show if_pc 0,4,8,C with if_inst=ROM[0..3]; fetch_count reaches 4 after four valid non-stalled cycles.
REQ-033 Stall for 3 cycles while if_pc=8 -> if_pc=8 and if_inst=ROM[2] held; fetch_count unchanged; after release, if_pc=C.
REQ-034 redirect_valid with redirect_pc=32'h00000097 at if_pc=C -> next cycle if_pc=32'h94, if_inst=ROM[0x25]; the C instruction is not counted.
REQ-035 Redirect and stall together, redirect_pc=32'h40 -> next cycle if_pc=32'h40, valid=1.
REQ-036 rst pulsed during a stall at if_pc=20 -> BOOT replayed, then if_pc=0, if_inst=ROM[0].
REQ-037 fetch_count forced to 32'hFFFFFFFF, one accepted instruction -> fetch_count 0; sequential fetch at PC 32'hFFFFFFFC -> next if_pc 0.
